// File: rtl/pfpu_pkg.sv
// Shared definitions for the PFPU issue scheduler: opcodes, per-opcode
// ALU latency, pipe depth and sticky error-bit positions.
package pfpu_pkg;

    typedef enum logic [3:0] {
        PFPU_OP_NOP   = 4'h0,
        PFPU_OP_FADD  = 4'h1,
        PFPU_OP_FSUB  = 4'h2,
        PFPU_OP_FMUL  = 4'h3,
        PFPU_OP_FDIV  = 4'h4,
        PFPU_OP_F2I   = 4'h5,
        PFPU_OP_I2F   = 4'h6,
        PFPU_OP_VECT  = 4'h7,
        PFPU_OP_SIN   = 4'h8,
        PFPU_OP_COS   = 4'h9,
        PFPU_OP_ABOVE = 4'ha
    } pfpu_op_e;

    // Longest ALU latency; the writeback pipe holds MAXLAT+1 entries.
    localparam int unsigned MAXLAT = 5;

    localparam int unsigned ERR_COLLISION = 0;
    localparam int unsigned ERR_RVALID    = 1;
    localparam int unsigned ERR_ILLEGAL   = 2;

    // Cycles from the alu_opcode cycle to alu_r_valid; 0 means "not issued".
    function automatic logic [2:0] pfpu_latency(input logic [3:0] op);
        logic [2:0] lat;
        case (op)
            PFPU_OP_FADD, PFPU_OP_FSUB, PFPU_OP_FDIV: lat = 3'd4;
            PFPU_OP_FMUL:                           lat = 3'd5;
            PFPU_OP_F2I, PFPU_OP_VECT, PFPU_OP_ABOVE: lat = 3'd2;
            PFPU_OP_I2F:                            lat = 3'd3;
            PFPU_OP_SIN, PFPU_OP_COS:               lat = 3'd4;
            default:                                lat = 3'd0;
        endcase
        return lat;
    endfunction

endpackage

// File: rtl/pfpu_wbpipe.sv
// Writeback reservation pipe. Entry i holds the write that happens i cycles
// from now; the pipe shifts down every cycle and entry 0 drives the write port.
module pfpu_wbpipe
    import pfpu_pkg::*;
#(
    parameter int unsigned RW    = 7,
    parameter int unsigned DEPTH = MAXLAT + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ins_en_i,
    input  logic [2:0]    ins_lat_i,
    input  logic [RW-1:0] ins_dest_i,
    input  logic [2:0]    qry_off_i,
    output logic          qry_busy_o,
    output logic          wb_en_o,
    output logic [RW-1:0] wb_addr_o,
    output logic          any_valid_o
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [RW-1:0]    dst_q [DEPTH];
    logic [RW-1:0]    dst_d [DEPTH];

    // Shift down one entry; a new op lands at entry L after the shift, which
    // is the slot that sits at L+1 before it (the one the query inspects).
    always_comb begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
            vld_d[i] = vld_q[i+1];
            dst_d[i] = dst_q[i+1];
        end
        vld_d[DEPTH-1] = 1'b0;
        dst_d[DEPTH-1] = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ins_en_i && (ins_lat_i == 3'(i))) begin
                vld_d[i] = 1'b1;
                dst_d[i] = ins_dest_i;
            end
        end
    end

    // Reservation lookup; offsets beyond the pipe are always free.
    always_comb begin
        qry_busy_o = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (qry_off_i == 3'(i)) qry_busy_o = vld_q[i];
        end
    end

    // Pipe state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) dst_q[i] <= '0;
        end else begin
            vld_q <= vld_d;
            for (int unsigned i = 0; i < DEPTH; i++) dst_q[i] <= dst_d[i];
        end
    end

    assign wb_en_o     = vld_q[0];
    assign wb_addr_o   = dst_q[0];
    assign any_valid_o = |vld_q;

endmodule

// File: rtl/pfpu_sched.sv
// PFPU issue scheduler: accepts instructions, stalls on RAW/WAW hazards and
// writeback-slot collisions, issues to the ALU and drives the writeback port.
module pfpu_sched
    import pfpu_pkg::*;
#(
    parameter int unsigned RW = 7
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_opcode,
    input  logic [RW-1:0] in_a,
    input  logic [RW-1:0] in_b,
    input  logic [RW-1:0] in_dest,
    output logic [3:0]    alu_opcode,
    output logic [RW-1:0] rf_a_addr,
    output logic [RW-1:0] rf_b_addr,
    input  logic          alu_r_valid,
    input  logic          alu_err_collision,
    output logic          wb_en,
    output logic [RW-1:0] wb_addr,
    output logic          busy,
    output logic [2:0]    err
);

    logic [2:0]       in_lat;
    logic             in_issuing, in_illegal;
    logic             hz_a, hz_b, hz_d, slot_busy;
    logic             accept, issue_go, pipe_any;
    logic [3:0]       op_q;
    logic [RW-1:0]    a_q, b_q;
    logic [2**RW-1:0] pend_q, pend_d;
    logic [2:0]       err_q, err_d;
    logic [2:0]       mask_q, mask_d;

    assign in_lat     = pfpu_latency(in_opcode);
    assign in_issuing = (in_lat != 3'd0);
    assign in_illegal = (in_opcode > PFPU_OP_ABOVE);

    // A pending register being written this very cycle does not block.
    assign hz_a = pend_q[in_a]    && !(wb_en && (wb_addr == in_a));
    assign hz_b = pend_q[in_b]    && !(wb_en && (wb_addr == in_b));
    assign hz_d = pend_q[in_dest] && !(wb_en && (wb_addr == in_dest));

    assign in_ready = !sys_rst &&
                      (!in_issuing || !(hz_a || hz_b || hz_d || slot_busy));
    assign accept   = in_valid && in_ready;
    assign issue_go = accept && in_issuing;

    pfpu_wbpipe #(
        .RW(RW)
    ) u_wbpipe (
        .clk_i       (sys_clk),
        .rst_i       (sys_rst),
        .ins_en_i    (issue_go),
        .ins_lat_i   (in_lat),
        .ins_dest_i  (in_dest),
        .qry_off_i   (in_lat + 3'd1),
        .qry_busy_o  (slot_busy),
        .wb_en_o     (wb_en),
        .wb_addr_o   (wb_addr),
        .any_valid_o (pipe_any)
    );

    // Issue register: opcode is a one-cycle pulse, read addresses hold.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            op_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            op_q <= issue_go ? in_opcode : '0;
            if (issue_go) begin
                a_q <= in_a;
                b_q <= in_b;
            end
        end
    end

    // Scoreboard, sticky errors and post-reset r_valid check mask.
    always_comb begin
        pend_d = pend_q;
        if (wb_en) pend_d[wb_addr] = 1'b0;
        if (issue_go) pend_d[in_dest] = 1'b1;

        err_d = err_q;
        if (alu_err_collision) err_d[ERR_COLLISION] = 1'b1;
        if ((mask_q == 3'd0) && (alu_r_valid != wb_en)) err_d[ERR_RVALID] = 1'b1;
        if (accept && in_illegal) err_d[ERR_ILLEGAL] = 1'b1;

        mask_d = (mask_q != 3'd0) ? mask_q - 3'd1 : mask_q;
    end

    // State registers for scoreboard, errors and check mask.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            pend_q <= '0;
            err_q  <= '0;
            mask_q <= 3'(MAXLAT);
        end else begin
            pend_q <= pend_d;
            err_q  <= err_d;
            mask_q <= mask_d;
        end
    end

    assign alu_opcode = op_q;
    assign rf_a_addr  = a_q;
    assign rf_b_addr  = b_q;
    assign busy       = (op_q != '0) || pipe_any;
    assign err        = err_q;

endmodule

// File: tb/tb_pfpu_sched.sv
// Directed scoreboard bench for pfpu_sched: the driver pushes hand-computed
// issue/writeback expectations, a monitor pops and compares them.
module tb_pfpu_sched;
    import pfpu_pkg::*;

    localparam int unsigned RW = 7;

    logic          sys_clk, sys_rst;
    logic          in_valid, in_ready;
    logic [3:0]    in_opcode;
    logic [RW-1:0] in_a, in_b, in_dest;
    logic [3:0]    alu_opcode;
    logic [RW-1:0] rf_a_addr, rf_b_addr;
    logic          alu_r_valid, alu_err_collision;
    logic          wb_en;
    logic [RW-1:0] wb_addr;
    logic          busy;
    logic [2:0]    err;

    pfpu_sched #(.RW(RW)) dut (
        .sys_clk           (sys_clk),
        .sys_rst           (sys_rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_opcode         (in_opcode),
        .in_a              (in_a),
        .in_b              (in_b),
        .in_dest           (in_dest),
        .alu_opcode        (alu_opcode),
        .rf_a_addr         (rf_a_addr),
        .rf_b_addr         (rf_b_addr),
        .alu_r_valid       (alu_r_valid),
        .alu_err_collision (alu_err_collision),
        .wb_en             (wb_en),
        .wb_addr           (wb_addr),
        .busy              (busy),
        .err               (err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc++;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [3:0] op; logic [RW-1:0] a; logic [RW-1:0] b; int cyc; } iss_t;
    typedef struct { logic [RW-1:0] d; int cyc; } wb_t;
    iss_t iss_q[$];
    wb_t  wb_q[$];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        total++;
        bad++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // ALU stand-in: raises r_valid exactly L cycles after each issue.
    function automatic int alu_lat(input logic [3:0] op);
        case (op)
            4'h1, 4'h2, 4'h4, 4'h8, 4'h9: return 4;
            4'h3:                         return 5;
            4'h5, 4'h7, 4'ha:             return 2;
            4'h6:                         return 3;
            default:                      return 0;
        endcase
    endfunction

    bit rv [64];
    initial alu_r_valid = 1'b0;
    always @(negedge sys_clk) begin
        alu_r_valid = rv[cyc % 64];
        rv[cyc % 64] = 1'b0;
        if (alu_opcode != 4'h0) rv[(cyc + alu_lat(alu_opcode)) % 64] = 1'b1;
    end

    // Monitor: pop expectations whenever the DUT issues or writes back.
    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (alu_opcode != 4'h0) begin
                if (iss_q.size() == 0) fail("issue_unexpected");
                else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    chk("issue_fields", {alu_opcode, rf_a_addr, rf_b_addr}, {e.op, e.a, e.b});
                    chk("issue_cycle", cyc, e.cyc);
                end
            end
            if (wb_en) begin
                if (wb_q.size() == 0) fail("wb_unexpected");
                else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    chk("wb_addr", wb_addr, w.d);
                    chk("wb_cycle", cyc, w.cyc);
                end
            end
        end
    end

    // Offer one instruction starting at a negedge; returns the accept cycle.
    task automatic send(input logic [3:0] op, input logic [RW-1:0] a, input logic [RW-1:0] b,
                        input logic [RW-1:0] d, input int lat, input int exp_wait,
                        input bit push_wb, output int acc);
        int waits;
        waits = 0;
        acc = -1;
        in_valid = 1'b1; in_opcode = op; in_a = a; in_b = b; in_dest = d;
        #1;
        while (!in_ready && waits < 30) begin
            @(negedge sys_clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            fail("accept_timeout");
            @(negedge sys_clk);
            in_valid = 1'b0;
            return;
        end
        chk("stall_cycles", waits, exp_wait);
        acc = cyc;
        if (lat != 0) iss_q.push_back('{op, a, b, acc + 1});
        if (push_wb) wb_q.push_back('{d, acc + 1 + lat});
        @(negedge sys_clk);
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outs();
        chk("rst_alu_opcode", alu_opcode, 0);
        chk("rst_rf_addrs", {rf_a_addr, rf_b_addr}, 0);
        chk("rst_wb", {wb_en, wb_addr}, 0);
        chk("rst_busy_err", {busy, err}, 0);
        chk("rst_in_ready", in_ready, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t, t2;
        sys_rst = 1'b1;
        in_valid = 1'b0; in_opcode = '0; in_a = '0; in_b = '0; in_dest = '0;
        alu_err_collision = 1'b0;

        repeat (2) @(negedge sys_clk);
        #1 chk_reset_outs();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1 chk("release_in_ready", in_ready, 1);

        // Single FADD 1,2 -> 3: issue at T+1, writeback T+5, idle at T+6.
        send(4'h1, 7'd1, 7'd2, 7'd3, 4, 0, 1'b1, t);
        chk("t1_rf_a", rf_a_addr, 1);
        repeat (4) @(negedge sys_clk);
        chk("t1_busy_T5", busy, 1);
        @(negedge sys_clk);
        chk("t1_busy_T6", busy, 0);
        chk("t1_err", err, 0);

        // Slot collision: F2I offered at T+2 targets the FADD slot, waits one.
        send(4'h1, 7'd0, 7'd0, 7'd4, 4, 0, 1'b1, t);
        @(negedge sys_clk);
        send(4'h5, 7'd8, 7'd9, 7'd5, 2, 1, 1'b1, t2);
        chk("t2_accept_cycle", t2 - t, 3);
        repeat (8) @(negedge sys_clk);

        // RAW: FADD reading r7 waits for the FMUL write cycle T+6.
        send(4'h3, 7'd10, 7'd11, 7'd7, 5, 0, 1'b1, t);
        send(4'h1, 7'd7, 7'd12, 7'd13, 4, 5, 1'b1, t2);
        chk("t3_accept_cycle", t2 - t, 6);
        repeat (8) @(negedge sys_clk);

        // Ten independent VECT ops back to back.
        for (int i = 0; i < 10; i++)
            send(4'h7, 7'(20 + i), 7'(40 + i), 7'(60 + i), 2, 0, 1'b1, t);
        repeat (8) @(negedge sys_clk);

        // Illegal opcode: accepted at once, no issue, err[2] sticks.
        send(4'hc, 7'd1, 7'd2, 7'd3, 0, 0, 1'b0, t);
        chk("t5_err", err, 3'b100);
        chk("t5_no_issue", alu_opcode, 0);
        send(4'h1, 7'd1, 7'd2, 7'd3, 4, 0, 1'b1, t);
        repeat (8) @(negedge sys_clk);

        // Reset mid-flight: FMUL result is dropped, no error follows.
        send(4'h3, 7'd1, 7'd2, 7'd9, 5, 0, 1'b0, t);
        @(negedge sys_clk);
        in_opcode = 4'h1; in_a = 7'd0; in_b = 7'd0; in_dest = 7'd1;
        sys_rst = 1'b1;
        #1 chk_reset_outs();
        @(negedge sys_clk);
        #1 chk_reset_outs();
        @(negedge sys_clk);
        sys_rst = 1'b0;
        #1 chk("t6_in_ready_after", in_ready, 1);
        repeat (8) @(negedge sys_clk);
        chk("t6_err", err, 0);
        chk("t6_busy", busy, 0);

        // Collision flag from the ALU is captured in err[0].
        alu_err_collision = 1'b1;
        @(negedge sys_clk);
        alu_err_collision = 1'b0;
        #1 chk("t7_err", err, 3'b001);

        chk("iss_q_drained", iss_q.size(), 0);
        chk("wb_q_drained", wb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pfpu_sched.md
# pfpu_sched

Issue scheduler for the PFPU ALU (`pfpu_alu`). It accepts a stream of instructions (opcode, two source registers, destination register) over a valid/ready handshake and issues them to the ALU one per cycle. It stalls on RAW/WAW hazards and on writeback-slot collisions, and drives the destination address for the register-file write port when each result emerges. It sits between the PFPU sequencer/program memory and the ALU/register file.

## Interface
- `RW`, 7: register address width (128 registers).
- `sys_clk`  in  1  system clock.
- `sys_rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction offered.
- `in_ready`  out  1  instruction accepted when `in_valid & in_ready`.
- `in_opcode`  in  4  ALU opcode.
- `in_a`  in  RW  source A register.
- `in_b`  in  RW  source B register.
- `in_dest`  in  RW  destination register.
- `alu_opcode`  out  4  opcode to ALU; registered, one-cycle pulse, 0 when idle.
- `rf_a_addr`  out  RW  register-file read address A; registered, valid with `alu_opcode`.
- `rf_b_addr`  out  RW  register-file read address B; registered, valid with `alu_opcode`.
- `alu_r_valid`  in  1  ALU result valid.
- `alu_err_collision`  in  1  ALU internal collision flag.
- `wb_en`  out  1  register-file write enable.
- `wb_addr`  out  RW  register-file write address.
- `busy`  out  1  any op in flight or issue register full.
- `err`  out  3  sticky flags: [0] ALU collision, [1] r_valid mismatch, [2] illegal opcode.

## Operation
- Latency L, counted from the `alu_opcode` cycle to the `alu_r_valid` cycle:
  - FADD(1)=4, FSUB(2)=4, FMUL(3)=5, FDIV(4)=4.
  - F2I(5)=2, I2F(6)=3, VECT(7)=2.
  - SIN(8)=4, COS(9)=4, ABOVE(a)=2.
  - MAXLAT=5.
- Opcode 0 is a NOP. It is accepted and consumes no slot; nothing is issued.
- Opcodes b–f: accepted, not issued, `err[2]` set.
- Scoreboard: 2^RW pending bits.
  - A bit is set on accept of an issuing op.
  - It is cleared at the end of that op's writeback cycle.
- Writeback pipe: MAXLAT+1 entries {valid, dest}.
  - Entry i means the write happens i cycles from now. Shifts down every cycle.
  - Entry 0 drives `wb_en`/`wb_addr`.
- `in_ready` is low if any of these holds:
  - `in_a` or `in_b` is pending (RAW).
  - `in_dest` is pending (WAW).
  - The writeback cycle the op would use is already reserved.
- Exception: a pending register whose write occurs in the current cycle does not block. Its value is written before the issued read.
- NOP and illegal opcodes ignore hazards (always ready).
- Checking:
  - If `alu_r_valid != wb_en` in any cycle, set `err[1]`.
  - If `alu_err_collision` is high, set `err[0]`.
  - `err` bits clear only on reset.
- `busy` = issue register valid OR any pipe entry valid.

## Timing
- Accept at cycle T:
  - `alu_opcode`, `rf_a_addr` and `rf_b_addr` are valid in T+1.
  - The register file returns operands in T+2.
  - `wb_en` is high in T+1+L.
- Throughput is one instruction per cycle when there are no hazards.
- `in_ready` is combinational from registered state and the `in_*` fields. It must not depend on `alu_r_valid`.
- Reset (asynchronous, any time, including mid-flight):
  - `in_ready`=0 while `sys_rst` is high, then 1 on the first cycle after release.
  - `alu_opcode`=0, `rf_*_addr`=0, `wb_en`=0, `wb_addr`=0, `busy`=0, `err`=0.
  - All pending bits and pipe entries are cleared.
  - In-flight results are discarded: `wb_en` stays low even if the ALU later asserts `r_valid`, and the resulting mismatch is not flagged for MAXLAT cycles after reset release.
- Simultaneous accept and writeback on the same register: pending is set (the new op wins).

## Structure
- Package `pfpu_pkg`:
  - opcode constants (`PFPU_OP_NOP`…`PFPU_OP_ABOVE`);
  - the `pfpu_latency(opcode)` function;
  - MAXLAT;
  - err bit indices.
- Sub-module `pfpu_wbpipe` holds the writeback shift pipe. It provides:
  - a reservation query at offset L+1;
  - insert;
  - the entry-0 output.

  The scoreboard and handshake stay in `pfpu_sched`.

## Test plan
- Single FADD accepted at T with a=1, b=2, dest=3:
  - `alu_opcode`=1 at T+1 and `rf_a_addr`=1;
  - `wb_en`=1 with `wb_addr`=3 at T+5;
  - `busy` falls at T+6; `err`=0.
- Collision: FADD (dest 4) at T, then F2I (dest 5) offered at T+2. Both target T+5, so:
  - `in_ready`=0 at T+2;
  - F2I is accepted at T+3 and writes back at T+6.
- RAW: FMUL dest 7 at T, then FADD a=7 offered at T+1:
  - stalls until T+6 (the write cycle), is accepted at T+6 and issues at T+7.
- Back-to-back independent VECT ops, 10 of them:
  - 10 consecutive issues;
  - `wb_en` high for 10 consecutive cycles with the dests in order.
- Opcode 0xc: accepted immediately, no issue, `err[2]`=1. A following FADD issues normally.
- Reset pulsed at T+2 during an in-flight FMUL:
  - all outputs are 0 during reset and `in_ready` is high the cycle after release;
  - no `wb_en` for the lost op;
  - `err` stays 0.
